uart_tx_frame: RTL and testbench

UART transmitter for the serial link. It accepts a parallel byte on a single-cycle valid strobe and serializes it onto `tx_out` as a frame: start bit, LSB-first data, optional parity, and stop bit. Each bit lasts a programmable number of clock cycles. It is the transmit-side counterpart of the RX path (sampler, start/parity/stop checkers) and shares its clock and reset.

---
 rtl/uart_tx_frame.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmitter. Accepts a parallel word on a one-cycle strobe
//            and shifts it out as start bit, LSB-first data, optional parity
//            and stop bit. Every bit lasts baud_div clock cycles (0 acts as 1).
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-low reset
//            p_data     - parallel data word to send
//            data_valid - request strobe, honoured only while idle
//            par_en     - 1 inserts a parity bit after the data bits
//            par_typ    - 0 even parity, 1 odd parity
//            baud_div   - clock cycles per bit
//            tx_out     - registered serial line, idles high
//            busy       - registered, high while a frame is in progress
//            done       - registered one-cycle pulse after the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int                  c_idx_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_idx_w-1:0]  c_idx_one  = {{(c_idx_w-1){1'b0}}, 1'b1};
  localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] c_div_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DIV_WIDTH-1:0]   r_baud_cnt;
  logic [DIV_WIDTH-1:0]   w_cnt_next;
  logic [c_idx_w-1:0]     r_bit_idx;
  logic [c_idx_w-1:0]     w_idx_next;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic [DIV_WIDTH-1:0]   r_div;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_bit_end;
  logic                   w_tx_next;
  logic                   w_busy_next;
  logic                   w_done_next;
  logic [DIV_WIDTH-1:0]   w_div_eff;

  assign w_accept  = (r_state == S_IDLE) && data_valid;
  assign w_div_eff = (baud_div == '0) ? c_div_one : baud_div;
  // Last cycle of the current bit period; r_div is never 0 once a frame runs.
  assign w_bit_end = (r_baud_cnt == (r_div - c_div_one));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_baud_cnt;
    w_idx_next   = r_bit_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      end
      default: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          case (r_state)
            S_START: begin
              w_state_next = S_DATA;
              w_idx_next   = '0;
            end
            S_DATA: begin
              if (r_bit_idx == c_idx_last) begin
                w_state_next = r_par_en ? S_PARITY : S_STOP;
              end else begin
                w_idx_next = r_bit_idx + c_idx_one;
              end
            end
            S_PARITY: w_state_next = S_STOP;
            S_STOP: begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end
            default:  w_state_next = S_IDLE;
          endcase
        end else begin
          w_cnt_next = r_baud_cnt + c_div_one;
        end
      end
    endcase
  end

  // Line level is derived from the next state so tx_out changes on the same
  // edge as the state register and stays a pure flop output.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_idx_next];
      S_PARITY: w_tx_next = r_par_bit;
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign w_busy_next = (w_state_next != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_div      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_cnt_next;
      r_bit_idx  <= w_idx_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      if (w_accept) begin
        r_data    <= p_data;
        r_par_en  <= par_en;
        r_par_bit <= (^p_data) ^ par_typ;
        r_div     <= w_div_eff;
      end
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. A frame-level model builds
//            the expected per-cycle line/busy/done sequence at each accepted
//            request; a compare process checks every cycle, and directed
//            tests pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  p_data = 8'h00;
  logic        data_valid = 1'b0;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic        tx_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .baud_div   (baud_div),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {
    logic tx;
    logic bsy;
    logic dn;
  } exp_t;

  exp_t exp_q[$];

  function automatic void build_frame(input logic [7:0] d, input logic pe,
                                      input logic pt, input logic [15:0] div);
    logic bits[$];
    int   n;
    exp_t e;
    n = (div == 16'd0) ? 1 : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < n; c++) begin
        e.tx = bits[k]; e.bsy = 1'b1; e.dn = 1'b0;
        exp_q.push_back(e);
      end
    end
    e.tx = 1'b1; e.bsy = 1'b0; e.dn = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Front of exp_q is the expectation for the current cycle.
  initial begin : model
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (data_valid && exp_q.size() == 0)
          build_frame(p_data, par_en, par_typ, baud_div);
      end
    end
  end

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q[0];
      else begin e.tx = 1'b1; e.bsy = 1'b0; e.dn = 1'b0; end
      chk("model_tx_out", {31'd0, tx_out}, {31'd0, e.tx});
      chk("model_busy",   {31'd0, busy},   {31'd0, e.bsy});
      chk("model_done",   {31'd0, done},   {31'd0, e.dn});
    end
  end

  // ---------------- directed stimulus ----------------
  logic tx_log   [0:63];
  logic busy_log [0:63];
  logic done_log [0:63];

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [15:0] div);
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; baud_div = div; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Index 0 is the cycle right after the acceptance edge.
  task automatic collect(input int n, input int poke_at, input logic [7:0] pd,
                         input logic [15:0] pdiv);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tx_log[i] = tx_out; busy_log[i] = busy; done_log[i] = done;
      if (i == poke_at) begin
        data_valid = 1'b1; p_data = pd; baud_div = pdiv;
      end else if (i == poke_at + 1) begin
        data_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    logic [9:0]  f_a;
    logic [9:0]  f_b;
    logic [7:0]  byte_v;
    logic        any;
    int          bcnt;

    #1 rst = 1'b0;
    idle(3);
    chk("reset_tx_out", {31'd0, tx_out}, 32'd1);
    chk("reset_busy",   {31'd0, busy},   32'd0);
    chk("reset_done",   {31'd0, done},   32'd0);
    #2 rst = 1'b1;
    idle(20);

    // 8N1, 0xA5, N=4
    send(8'hA5, 1'b0, 1'b0, 16'd4);
    collect(44, -1, 8'h00, 16'd0);
    bcnt = 0;
    for (int k = 0; k < 10; k++) begin
      f_a[k] = tx_log[4*k];
      f_b[k] = tx_log[4*k+3];
    end
    for (int i = 0; i < 44; i++) if (busy_log[i]) bcnt++;
    chk("a5_bits_first", {22'd0, f_a}, {22'd0, 10'b1101001010});
    chk("a5_bits_last",  {22'd0, f_b}, {22'd0, 10'b1101001010});
    chk("a5_done_40",    {31'd0, done_log[40]}, 32'd1);
    chk("a5_done_39",    {31'd0, done_log[39]}, 32'd0);
    chk("a5_busy_len",   bcnt, 32'd40);
    idle(3);

    // parity, N=1
    send(8'hA5, 1'b1, 1'b0, 16'd1);
    collect(14, -1, 8'h00, 16'd0);
    chk("par_even_a5", {31'd0, tx_log[9]}, 32'd0);
    chk("par_done_11", {31'd0, done_log[11]}, 32'd1);
    chk("par_done_10", {31'd0, done_log[10]}, 32'd0);
    idle(2);
    send(8'hA5, 1'b1, 1'b1, 16'd1);
    collect(14, -1, 8'h00, 16'd0);
    chk("par_odd_a5", {31'd0, tx_log[9]}, 32'd1);
    idle(2);
    send(8'h07, 1'b1, 1'b0, 16'd1);
    collect(14, -1, 8'h00, 16'd0);
    chk("par_even_07", {31'd0, tx_log[9]}, 32'd1);
    idle(2);

    // ignored request and frozen inputs: 0x00 at N=2, poke 0xFF / N=7 mid-frame
    send(8'h00, 1'b0, 1'b0, 16'd2);
    collect(30, 6, 8'hFF, 16'd7);
    any = 1'b0;
    for (int i = 2; i < 18; i++) any = any | tx_log[i];
    chk("ign_data_zero", {31'd0, any}, 32'd0);
    chk("ign_stop",      {31'd0, tx_log[18]}, 32'd1);
    chk("ign_done_20",   {31'd0, done_log[20]}, 32'd1);
    chk("ign_no_second", {31'd0, busy_log[25]}, 32'd0);
    idle(3);

    // back-to-back: request in the done cycle of a 0x3C frame
    send(8'h3C, 1'b0, 1'b0, 16'd1);
    collect(25, 10, 8'hC3, 16'd1);
    for (int j = 0; j < 8; j++) byte_v[j] = tx_log[1+j];
    chk("b2b_first",     {24'd0, byte_v}, 32'h3C);
    chk("b2b_done",      {31'd0, done_log[10]}, 32'd1);
    chk("b2b_start_tx",  {31'd0, tx_log[11]}, 32'd0);
    chk("b2b_start_bsy", {31'd0, busy_log[11]}, 32'd1);
    for (int j = 0; j < 8; j++) byte_v[j] = tx_log[12+j];
    chk("b2b_second",    {24'd0, byte_v}, 32'hC3);
    chk("b2b_done2",     {31'd0, done_log[21]}, 32'd1);
    idle(3);

    // baud_div = 0 behaves as 1
    send(8'h5A, 1'b0, 1'b0, 16'd0);
    collect(12, -1, 8'h00, 16'd0);
    for (int j = 0; j < 8; j++) byte_v[j] = tx_log[1+j];
    chk("div0_data", {24'd0, byte_v}, 32'h5A);
    chk("div0_done", {31'd0, done_log[10]}, 32'd1);
    idle(3);

    // reset during data bit 3 of 0xF0 at N=3 (bit k=4 spans indices 12..14)
    send(8'hF0, 1'b0, 1'b0, 16'd3);
    idle(13);
    chk("rst_pre_busy", {31'd0, busy},   32'd1);
    chk("rst_pre_tx",   {31'd0, tx_out}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx",   {31'd0, tx_out}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy},   32'd0);
    chk("rst_mid_done", {31'd0, done},   32'd0);
    idle(3);
    #2 rst = 1'b1;
    idle(3);

    // frame after reset: 0x81, odd parity, N=2
    send(8'h81, 1'b1, 1'b1, 16'd2);
    collect(26, -1, 8'h00, 16'd0);
    for (int j = 0; j < 8; j++) byte_v[j] = tx_log[2+2*j];
    chk("post_rst_data", {24'd0, byte_v}, 32'h81);
    chk("post_rst_par",  {31'd0, tx_log[18]}, 32'd1);
    chk("post_rst_done", {31'd0, done_log[22]}, 32'd1);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
